counter_apb_slave: RTL and testbench
====================================

Name: counter_apb_slave

Overview:
- APB3-style slave wrapping a programmable 32-bit up/down counter with a limit register and a sticky wrap flag.
- Software starts, stops, clears, loads and reads the counter through a 4-bit register address space.
- Zero-wait-state peripheral on the system APB bus.

Parameters:
- CNT_W, 32, counter/limit/load width (1..32); read values zero-extended to 32 bits, write data truncated to CNT_W.

Ports:
- clk  input  1  system clock, all state on rising edge
- rstn  input  1  synchronous active-high reset (reset when 1, sampled on rising clk)
- PSEL  input  1  APB slave select
- PENABLE  input  1  APB access phase
- PWRITE  input  1  1 = write, 0 = read
- PADDR  input  4  word register index
- PWDATA  input  32  write data
- PRDATA  output  32  read data
- PREADY  output  1  transfer complete, tied 1

Behaviour:
- Register map (PADDR):
  - 0x0 LOAD: RW, reset 0.
  - 0x1 LIMIT: RW, reset all ones.
  - 0x2 CTRL: RW.
    - bit0 EN; bit1 DIR (0 up, 1 down); bit4 IE.
    - bit2 CLR and bit3 LD are write-only strobes; they read 0.
    - Reset 0.
  - 0x3 COUNT: RO, reset 0.
  - 0x4 STATUS: bit0 WRAP, sticky, write-1-to-clear.
  - Other addresses: read 0, writes ignored. Writes to COUNT ignored.
- Write commits on the rising edge where PSEL & PENABLE & PWRITE = 1.
- PREADY is constant 1, so every access completes in one access cycle.
- PRDATA is combinational:
  - equals the addressed register when PSEL = 1 and PWRITE = 0;
  - otherwise 0.
  - It does not depend on PENABLE.
- Counting: on each rising edge where the registered EN = 1:
  - Up: if COUNT == LIMIT, COUNT <= 0 and WRAP <= 1; else COUNT + 1.
  - Down: if COUNT == 0, COUNT <= LIMIT and WRAP <= 1; else COUNT - 1.
- EN written at edge T takes effect from edge T+1, so COUNT = N after N further edges.
- Priority in one cycle, highest first: reset, CLR strobe (COUNT <= 0), LD strobe (COUNT <= LOAD), count step.
  - A strobe cycle does not count.
  - LD uses the LOAD value held before that edge.
- Setting CLR and LD together: CLR wins.
- STATUS write-1 to bit0 in the same edge as a wrap event: WRAP stays 1 (set wins).
- LIMIT changed below current COUNT while counting up: counter continues up to all ones, wraps to 0 (natural modulo 2^CNT_W, WRAP set), then obeys LIMIT.
- rstn = 1 at any edge returns all registers and COUNT to reset values, aborting counting; PRDATA follows the combinational rule.
- No error response; PSLVERR not implemented.

Optional Feature:
- Macro COUNTER_APB_IRQ_EN.
- Defined: adds output port irq (1 bit) = registered (WRAP & CTRL.IE), updated one edge after either changes, reset 0.
- Undefined: no irq port; CTRL.IE bit remains RW storage with no effect.

Test Plan:
- Reset: hold rstn = 1 two edges, release → PRDATA reads 0 at 0x3, 0xFFFFFFFF at 0x1, 0 at 0x2 and 0x4; PREADY = 1 throughout.
- Count up: write CTRL = 0x1 at edge T, keep PSEL high, read 0x3 after 20 further edges → PRDATA = 20; CTRL reads 0x1.
- Limit wrap: LIMIT = 3, CTRL = 0x1 → COUNT sequence 1,2,3,0,1; STATUS reads 1; write STATUS = 1 → reads 0.
- Down/load: LOAD = 5, write CTRL = 0xB (EN|DIR|LD) → COUNT = 5 next edge, then 4,3; after reaching 0 with LIMIT = 7, next value 7 and WRAP = 1.
- Clear priority: write CTRL = 0xD (EN|CLR|LD) while counting at 9 → COUNT = 0 next edge, 1 the edge after; CTRL reads 0x1.
- Boundary: write to 0x3 and 0xF ignored; read 0xF → 0. Assert rstn mid-count → COUNT 0 and EN 0 after that edge.

Source files
------------

// File: rtl/counter_apb_slave.sv
// counter_apb_slave: zero-wait-state APB3 slave around a programmable up/down
// counter with a LIMIT register, a sticky WRAP flag and CLR/LD strobes.
// Register map (word index on PADDR):
//   0x0 LOAD  (RW)   0x1 LIMIT (RW)   0x2 CTRL (RW: EN, DIR, IE; CLR/LD strobes)
//   0x3 COUNT (RO)   0x4 STATUS (bit0 WRAP, write-1-to-clear)
// Optional feature: define COUNTER_APB_IRQ_EN to add a registered irq output
// equal to WRAP & CTRL.IE. Without it, IE is plain storage.
module counter_apb_slave #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY
`ifdef COUNTER_APB_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [3:0] ADDR_LOAD   = 4'h0;
  localparam logic [3:0] ADDR_LIMIT  = 4'h1;
  localparam logic [3:0] ADDR_CTRL   = 4'h2;
  localparam logic [3:0] ADDR_COUNT  = 4'h3;
  localparam logic [3:0] ADDR_STATUS = 4'h4;

  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] limit_val;
  logic [CNT_W-1:0] count;
  logic             en;
  logic             dir;
  logic             ie;
  logic             wrap;

  logic             wr;
  logic             clr_strobe;
  logic             ld_strobe;
  logic             w1c_wrap;
  logic [CNT_W:0]   step;
  logic             step_wrap;
  logic [CNT_W-1:0] step_val;

  // Zero-extend a counter-width value onto the 32-bit read bus.
  function automatic logic [31:0] zext(input logic [CNT_W-1:0] v);
    logic [31:0] r;
    r = '0;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  // One count step: returns {wrap_event, next_value}. Counting up also wraps
  // naturally past all ones, which covers LIMIT being lowered below COUNT.
  function automatic logic [CNT_W:0] next_count(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] lim,
                                                input logic             down);
    logic [CNT_W:0] r;
    if (down) begin
      if (cnt == '0) r = {1'b1, lim};
      else           r = {1'b0, cnt - CNT_W'(1)};
    end else begin
      if (cnt == lim) r = {1'b1, {CNT_W{1'b0}}};
      else            r = {(cnt == {CNT_W{1'b1}}), cnt + CNT_W'(1)};
    end
    return r;
  endfunction

  assign PREADY     = 1'b1;
  assign wr         = PSEL & PENABLE & PWRITE;
  assign clr_strobe = wr && (PADDR == ADDR_CTRL) && PWDATA[2];
  assign ld_strobe  = wr && (PADDR == ADDR_CTRL) && PWDATA[3];
  assign w1c_wrap   = wr && (PADDR == ADDR_STATUS) && PWDATA[0];
  assign step       = next_count(count, limit_val, dir);
  assign step_wrap  = step[CNT_W];
  assign step_val   = step[CNT_W-1:0];

  // Software-visible configuration registers.
  always_ff @(posedge clk) begin
    if (rstn) begin
      load_val  <= '0;
      limit_val <= '1;
      en        <= 1'b0;
      dir       <= 1'b0;
      ie        <= 1'b0;
    end else if (wr) begin
      case (PADDR)
        ADDR_LOAD:  load_val  <= PWDATA[CNT_W-1:0];
        ADDR_LIMIT: limit_val <= PWDATA[CNT_W-1:0];
        ADDR_CTRL: begin
          en  <= PWDATA[0];
          dir <= PWDATA[1];
          ie  <= PWDATA[4];
        end
        default: ;
      endcase
    end
  end

  // Counter and sticky wrap flag; CLR beats LD beats counting, set beats clear.
  always_ff @(posedge clk) begin
    if (rstn) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      if (clr_strobe) begin
        count <= '0;
      end else if (ld_strobe) begin
        count <= load_val;
      end else if (en) begin
        count <= step_val;
      end

      if (en && !clr_strobe && !ld_strobe && step_wrap) begin
        wrap <= 1'b1;
      end else if (w1c_wrap) begin
        wrap <= 1'b0;
      end
    end
  end

`ifdef COUNTER_APB_IRQ_EN
  // Interrupt follows WRAP & IE one edge later.
  always_ff @(posedge clk) begin
    if (rstn) irq <= 1'b0;
    else      irq <= wrap & ie;
  end
`endif

  // Combinational read mux, independent of PENABLE.
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        ADDR_LOAD:   PRDATA = zext(load_val);
        ADDR_LIMIT:  PRDATA = zext(limit_val);
        ADDR_CTRL:   PRDATA = {27'b0, ie, 2'b00, dir, en};
        ADDR_COUNT:  PRDATA = zext(count);
        ADDR_STATUS: PRDATA = {31'b0, wrap};
        default:     PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_apb_slave.sv
// Directed bench for counter_apb_slave with hand-computed expected values.
module tb_counter_apb_slave;

  logic        clk;
  logic        rstn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
`ifdef COUNTER_APB_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;

  counter_apb_slave #(.CNT_W(32)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY)
`ifdef COUNTER_APB_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Setup phase on one edge, access phase commits on the following edge.
  // Returns 1ns after the commit edge; two clock edges elapse in total.
  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(negedge clk);
    PENABLE = 1'b1;
    @(posedge clk);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr;
    #1;
    check(tag, PRDATA, exp);
    PSEL = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    rstn = 1'b1;

    // Reset values
    step(2);
    rstn = 1'b0;
    apb_read("rst_count",  4'h3, 32'h0);
    apb_read("rst_limit",  4'h1, 32'hFFFF_FFFF);
    apb_read("rst_ctrl",   4'h2, 32'h0);
    apb_read("rst_status", 4'h4, 32'h0);
    apb_read("rst_load",   4'h0, 32'h0);
    check("pready", {31'b0, PREADY}, 32'h1);

    // Count up: N edges after the enabling write gives COUNT = N
    apb_write(4'h2, 32'h1);
    step(20);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = 4'h3; PENABLE = 1'b0;
    #1 check("up20", PRDATA, 32'd20);
    apb_read("up_ctrl", 4'h2, 32'h1);
    apb_write(4'h2, 32'h0);           // counts to 22 during the write, then stops
    apb_read("stop22", 4'h3, 32'd22);
    apb_write(4'h2, 32'h4);           // CLR
    apb_read("clr0", 4'h3, 32'h0);

    // Limit wrap 1,2,3,0,1 and write-1-to-clear
    apb_write(4'h1, 32'd3);
    apb_write(4'h2, 32'h1);
    step(1); apb_read("lim_1", 4'h3, 32'd1);
    apb_read("lim_nowrap", 4'h4, 32'h0);
    step(1); apb_read("lim_2", 4'h3, 32'd2);
    step(1); apb_read("lim_3", 4'h3, 32'd3);
    step(1); apb_read("lim_0", 4'h3, 32'd0);
    step(1); apb_read("lim_1b", 4'h3, 32'd1);
    apb_read("lim_wrap", 4'h4, 32'h1);
    apb_write(4'h2, 32'h0);           // 1 -> 2 -> 3 then stopped
    apb_read("lim_stop3", 4'h3, 32'd3);
    apb_write(4'h4, 32'h1);
    apb_read("w1c", 4'h4, 32'h0);

    // Down with load, wrap to LIMIT
    apb_write(4'h0, 32'd5);
    apb_write(4'h1, 32'd7);
    apb_write(4'h2, 32'hB);           // EN|DIR|LD
    apb_read("ld5", 4'h3, 32'd5);
    apb_read("dn_ctrl", 4'h2, 32'h3);
    step(1); apb_read("dn4", 4'h3, 32'd4);
    step(1); apb_read("dn3", 4'h3, 32'd3);
    step(3); apb_read("dn0", 4'h3, 32'd0);
    apb_read("dn_nowrap", 4'h4, 32'h0);
    step(1); apb_read("dn7", 4'h3, 32'd7);
    apb_read("dn_wrap", 4'h4, 32'h1);
    apb_write(4'h2, 32'h4);           // CLR, EN off
    apb_read("dn_clr", 4'h3, 32'h0);
    apb_write(4'h4, 32'h1);

    // CLR beats LD while counting at 9
    apb_write(4'h1, 32'd100);
    apb_write(4'h2, 32'h1);
    step(8); apb_read("pre8", 4'h3, 32'd8);
    apb_write(4'h2, 32'hD);           // counts to 9, then CLR|LD commits
    apb_read("clrld0", 4'h3, 32'd0);
    apb_read("clrld_ctrl", 4'h2, 32'h1);
    step(1); apb_read("clrld1", 4'h3, 32'd1);

    // Ignored writes and unmapped reads
    apb_write(4'h3, 32'h55);          // counting continues 1 -> 3
    apb_read("ro_count", 4'h3, 32'd3);
    apb_write(4'hF, 32'h1234);        // 3 -> 5
    apb_read("unmapped", 4'hF, 32'h0);
    apb_read("after_unm", 4'h3, 32'd5);

    // Reset mid-count
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1 rstn = 1'b0;
    apb_read("mid_rst_cnt",  4'h3, 32'h0);
    apb_read("mid_rst_ctrl", 4'h2, 32'h0);
    apb_read("mid_rst_lim",  4'h1, 32'hFFFF_FFFF);
    step(3); apb_read("mid_rst_idle", 4'h3, 32'h0);

    // WRAP set wins over a same-edge write-1-to-clear
    apb_write(4'h1, 32'd1);
    apb_write(4'h2, 32'h1);
    apb_write(4'h4, 32'h1);           // count 0 -> 1 -> 0 (wrap) on commit edge
    apb_read("setwin", 4'h4, 32'h1);
    apb_read("setwin_cnt", 4'h3, 32'h0);
    apb_write(4'h4, 32'h1);           // 0 -> 1 -> 0 wrap again on commit edge
    apb_read("setwin2", 4'h4, 32'h1);
    step(1);
    apb_write(4'h4, 32'h1);           // 1 -> 0 (wrap) -> 1, clear on commit edge
    apb_read("clr_late", 4'h4, 32'h0);
    check("pready_end", {31'b0, PREADY}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
